// File: rtl/regfile_wb_scheduler_pkg.sv
// Shared widths and requester ids for the GPR writeback scheduler.
package regfile_wb_scheduler_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int NREG   = 2 ** REG_AW;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_LSU = 1'b1;
endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, rr_last flop moves only on conflicts.
import regfile_wb_scheduler_pkg::*;

module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    logic rr_last;
    logic conflict;

    assign conflict = req[REQ_ALU] & req[REQ_LSU];

    always_comb begin
        gnt = req;
        if (conflict) begin
            gnt = '0;
            if (rr_last == REQ_LSU) gnt[REQ_ALU] = 1'b1;
            else                    gnt[REQ_LSU] = 1'b1;
        end
    end

    // Reset to LSU so the first conflict after reset goes to the ALU.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last <= REQ_LSU;
        end else if (conflict) begin
            rr_last <= gnt[REQ_LSU] ? REQ_LSU : REQ_ALU;
        end
    end
endmodule

// File: rtl/regfile_wb_scheduler.sv
// GPR write-port owner: pending-destination scoreboard, hazard stall, ALU/LSU
// writeback arbitration onto a single registered write port.
import regfile_wb_scheduler_pkg::*;

module regfile_wb_scheduler (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic [REG_AW-1:0] issue_rs1,
    input  logic [REG_AW-1:0] issue_rs2,
    output logic              issue_ready,
    input  logic              alu_wb_valid,
    input  logic [REG_AW-1:0] alu_wb_addr,
    input  logic [XLEN-1:0]   alu_wb_data,
    output logic              alu_wb_ready,
    input  logic              lsu_wb_valid,
    input  logic [REG_AW-1:0] lsu_wb_addr,
    input  logic [XLEN-1:0]   lsu_wb_data,
    output logic              lsu_wb_ready,
    output logic              rf_wen,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic [NREG-1:0]   busy_o,
    output logic              wb_err
);
    logic [NREG-1:0]   busy;
    logic [NREG-1:0]   busy_nxt;
    logic [1:0]        req;
    logic [1:0]        gnt;
    logic              wb_hs;
    logic [REG_AW-1:0] wb_addr;
    logic [XLEN-1:0]   wb_data;

    assign req[REQ_ALU] = alu_wb_valid;
    assign req[REQ_LSU] = lsu_wb_valid;

    rr_arbiter2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    assign alu_wb_ready = gnt[REQ_ALU];
    assign lsu_wb_ready = gnt[REQ_LSU];
    assign wb_hs        = |gnt;
    assign wb_addr      = gnt[REQ_LSU] ? lsu_wb_addr : alu_wb_addr;
    assign wb_data      = gnt[REQ_LSU] ? lsu_wb_data : alu_wb_data;

    assign issue_ready = !(busy[issue_rs1] | busy[issue_rs2] | busy[issue_rd]);
    assign busy_o      = busy;

    // Clear follows the visible write by one edge so a stalled reader unstalls
    // exactly when the new value is in the register file.
    always_comb begin
        busy_nxt = busy;
        if (rf_wen) busy_nxt[rf_waddr] = 1'b0;
        if (issue_valid && issue_ready && (issue_rd != '0)) busy_nxt[issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            rf_wen   <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            wb_err   <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (wb_hs) begin
                rf_wen   <= (wb_addr != '0);
                rf_waddr <= wb_addr;
                rf_wdata <= wb_data;
                if ((wb_addr != '0) && !busy[wb_addr]) wb_err <= 1'b1;
            end else begin
                rf_wen <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Randomized scoreboard bench for regfile_wb_scheduler with a behavioural reference model.
module tb_regfile_wb_scheduler;
    import regfile_wb_scheduler_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              issue_valid = 1'b0;
    logic [REG_AW-1:0] issue_rd = '0, issue_rs1 = '0, issue_rs2 = '0;
    logic              issue_ready;
    logic              alu_wb_valid = 1'b0;
    logic [REG_AW-1:0] alu_wb_addr = '0;
    logic [XLEN-1:0]   alu_wb_data = '0;
    logic              alu_wb_ready;
    logic              lsu_wb_valid = 1'b0;
    logic [REG_AW-1:0] lsu_wb_addr = '0;
    logic [XLEN-1:0]   lsu_wb_data = '0;
    logic              lsu_wb_ready;
    logic              rf_wen;
    logic [REG_AW-1:0] rf_waddr;
    logic [XLEN-1:0]   rf_wdata;
    logic [NREG-1:0]   busy_o;
    logic              wb_err;

    always #5 clk = ~clk;

    regfile_wb_scheduler dut (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rs1(issue_rs1),
        .issue_rs2(issue_rs2), .issue_ready(issue_ready),
        .alu_wb_valid(alu_wb_valid), .alu_wb_addr(alu_wb_addr),
        .alu_wb_data(alu_wb_data), .alu_wb_ready(alu_wb_ready),
        .lsu_wb_valid(lsu_wb_valid), .lsu_wb_addr(lsu_wb_addr),
        .lsu_wb_data(lsu_wb_data), .lsu_wb_ready(lsu_wb_ready),
        .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy_o(busy_o), .wb_err(wb_err)
    );

    typedef struct {
        logic [REG_AW-1:0] addr;
        logic [XLEN-1:0]   data;
    } wr_t;

    wr_t               exp_wq[$];
    bit                mb[NREG];
    bit                m_last_lsu;
    bit                m_wr_valid;
    logic [REG_AW-1:0] m_wr_addr;
    bit                m_err;
    bit                g_alu, g_lsu;
    int                n_vec = 0;
    int                n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        foreach (mb[i]) mb[i] = 1'b0;
        m_last_lsu = 1'b1;
        m_wr_valid = 1'b0;
        m_wr_addr  = '0;
        m_err      = 1'b0;
        exp_wq.delete();
    endtask

    // Called at posedge+1 with inputs set; checks at negedge, advances the model, returns at posedge+1.
    task automatic step();
        bit                exp_rdy;
        bit                both;
        logic [NREG-1:0]   exp_busy;
        logic [REG_AW-1:0] a;
        logic [XLEN-1:0]   d;
        @(negedge clk);
        exp_rdy = !(mb[issue_rs1] || mb[issue_rs2] || mb[issue_rd]);
        both    = alu_wb_valid && lsu_wb_valid;
        g_alu   = alu_wb_valid && (!lsu_wb_valid || m_last_lsu);
        g_lsu   = lsu_wb_valid && !g_alu;
        for (int i = 0; i < NREG; i++) exp_busy[i] = mb[i];
        chk("issue_ready", 64'(issue_ready), 64'(exp_rdy));
        chk("alu_wb_ready", 64'(alu_wb_ready), 64'(g_alu));
        chk("lsu_wb_ready", 64'(lsu_wb_ready), 64'(g_lsu));
        chk("rf_wen", 64'(rf_wen), 64'(m_wr_valid));
        chk("busy_o", 64'(busy_o), 64'(exp_busy));
        chk("wb_err", 64'(wb_err), 64'(m_err));
        a = g_lsu ? lsu_wb_addr : alu_wb_addr;
        d = g_lsu ? lsu_wb_data : alu_wb_data;
        if ((g_alu || g_lsu) && a != 0 && !mb[a]) m_err = 1'b1;
        if (m_wr_valid) mb[m_wr_addr] = 1'b0;
        if (issue_valid && exp_rdy && issue_rd != 0) mb[issue_rd] = 1'b1;
        if ((g_alu || g_lsu) && a != 0) begin
            exp_wq.push_back('{addr: a, data: d});
            m_wr_valid = 1'b1;
            m_wr_addr  = a;
        end else begin
            m_wr_valid = 1'b0;
        end
        if (both) m_last_lsu = g_lsu;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0; issue_rd = '0; issue_rs1 = '0; issue_rs2 = '0;
        alu_wb_valid = 1'b0; lsu_wb_valid = 1'b0;
    endtask

    function automatic logic [REG_AW-1:0] pick_addr();
        int cand[$];
        for (int i = 1; i < NREG; i++) if (mb[i]) cand.push_back(i);
        if (cand.size() > 0 && $urandom_range(0, 3) != 0)
            return REG_AW'(cand[$urandom_range(0, cand.size() - 1)]);
        return REG_AW'($urandom_range(0, NREG - 1));
    endfunction

    // Monitor: every visible write must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && rf_wen) begin
            if (exp_wq.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected none", rf_waddr, rf_wdata);
            end else begin
                wr_t e;
                e = exp_wq.pop_front();
                chk("rf_waddr", 64'(rf_waddr), 64'(e.addr));
                chk("rf_wdata", 64'(rf_wdata), 64'(e.data));
            end
        end
    end

    initial begin
        bit [2:0] seq;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        step();

        // RAW stall on x5 until the edge after the write is visible
        issue_valid = 1'b1; issue_rd = 5'd5; step();
        issue_rd = 5'd0; issue_rs1 = 5'd5; step();
        alu_wb_valid = 1'b1; alu_wb_addr = 5'd5; alu_wb_data = 32'hDEADBEEF; step();
        alu_wb_valid = 1'b0; step();
        step();
        chk("raw_unstall", 64'(issue_ready), 64'd1);

        // Plain ALU write to x3 and address-0 writeback
        idle(); issue_valid = 1'b1; issue_rd = 5'd3; step();
        idle(); alu_wb_valid = 1'b1; alu_wb_addr = 5'd3; alu_wb_data = 32'hDEADBEEF; step();
        idle(); lsu_wb_valid = 1'b1; lsu_wb_addr = 5'd0; lsu_wb_data = 32'h1234; step();
        idle(); step(); step();
        chk("addr0_no_err", 64'(wb_err), 64'd0);

        // Writeback to non-busy x7 sets sticky error
        alu_wb_valid = 1'b1; alu_wb_addr = 5'd7; alu_wb_data = 32'h77; step();
        idle(); step(); step();
        chk("wb_err_sticky", 64'(wb_err), 64'd1);

        // Three-way conflict sequence: ALU, LSU, ALU
        alu_wb_valid = 1'b1; alu_wb_addr = 5'd10; alu_wb_data = 32'h1;
        lsu_wb_valid = 1'b1; lsu_wb_addr = 5'd11; lsu_wb_data = 32'h2;
        step(); seq[2] = g_alu;
        alu_wb_addr = 5'd12; alu_wb_data = 32'h3;
        step(); seq[1] = g_alu;
        lsu_wb_addr = 5'd13; lsu_wb_data = 32'h4;
        step(); seq[0] = g_alu;
        chk("conflict_seq", 64'(seq), 64'b101);
        idle(); step(); step();

        // Reset with busy=0x110 and a write in flight
        issue_valid = 1'b1; issue_rd = 5'd4; step();
        issue_rd = 5'd8; step();
        idle(); step();
        alu_wb_valid = 1'b1; alu_wb_addr = 5'd4; alu_wb_data = 32'hAA; step();
        idle();
        rst = 1'b1;
        #1;
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_wen", 64'(rf_wen), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        alu_wb_valid = 1'b1; alu_wb_addr = 5'd1; alu_wb_data = 32'h5;
        lsu_wb_valid = 1'b1; lsu_wb_addr = 5'd2; lsu_wb_data = 32'h6;
        step();
        chk("post_rst_alu_first", 64'(g_alu), 64'd1);
        idle(); step(); step();

        // Randomized traffic; ungranted requesters hold their request
        for (int n = 0; n < 3000; n++) begin
            issue_valid = ($urandom_range(0, 1) == 1);
            issue_rd  = REG_AW'($urandom_range(0, 3) == 0 ? $urandom_range(0, 31) : $urandom_range(0, 7));
            issue_rs1 = REG_AW'($urandom_range(0, 7));
            issue_rs2 = REG_AW'($urandom_range(0, 7));
            if (!alu_wb_valid || g_alu) begin
                alu_wb_valid = ($urandom_range(0, 99) < 55);
                alu_wb_addr  = pick_addr();
                alu_wb_data  = $urandom;
            end
            if (!lsu_wb_valid || g_lsu) begin
                lsu_wb_valid = ($urandom_range(0, 99) < 45);
                lsu_wb_addr  = pick_addr();
                lsu_wb_data  = $urandom;
            end
            step();
        end
        idle(); step(); step(); step();
        chk("drain", 64'(exp_wq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
